// File: rtl/cpu_0_mult_pkg.sv
// Shared constants, FSM encoding and helpers for the sequential multiply unit.
package cpu_0_mult_pkg;

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_MULXUU = 2'b01;
    localparam logic [1:0] MODE_MULXSU = 2'b10;
    localparam logic [1:0] MODE_MULXSS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The high-half product hi1*hi2 only lands above the low word, so MUL skips it.
    function automatic logic [2:0] num_pp(input logic [1:0] mode);
        return (mode == MODE_MUL) ? 3'd3 : 3'd4;
    endfunction

endpackage

// File: rtl/cpu_0_mult_half_cell.sv
// Registered unsigned half-width multiplier; one product per cycle, 1-cycle latency.
module cpu_0_mult_half_cell #(
    parameter int HW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [HW-1:0]   a,
    input  logic [HW-1:0]   b,
    output logic [2*HW-1:0] p
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) p <= '0;
        else          p <= a * b;
    end

endmodule

// File: rtl/cpu_0_mult_seq_unit.sv
// Multi-cycle WIDTHxWIDTH multiply: four (or three) half-width partial products
// accumulated in 2*WIDTH bits, sign applied once at the end.
module cpu_0_mult_seq_unit
    import cpu_0_mult_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SIGN_MODES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int H  = WIDTH / 2;
    localparam int AW = 2 * WIDTH;

    state_t           state, state_nxt;
    logic [1:0]       k, mode_q, pp_k;
    logic             neg_q, pp_vld, accept, last_k;
    logic             signed_en, sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2, cell_p;
    logic [H-1:0]     cell_a, cell_b;
    logic [AW-1:0]    acc, pp_ext, acc_sum, prod;

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign accept = start && (state == ST_IDLE);
    assign last_k = ({1'b0, k} == num_pp(mode_q) - 3'd1);

    assign signed_en = (SIGN_MODES != 0) && mode[1];
    assign sign1     = signed_en && src1[WIDTH-1];
    assign sign2     = signed_en && (mode == MODE_MULXSS) && src2[WIDTH-1];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)  state_nxt = ST_ISSUE;
            ST_ISSUE: if (last_k) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Issue order: lo*lo, lo1*hi2, hi1*lo2, hi*hi.
    always_comb begin
        cell_a = mag1[H-1:0];
        cell_b = mag2[H-1:0];
        case (k)
            2'd1: cell_b = mag2[WIDTH-1:H];
            2'd2: cell_a = mag1[WIDTH-1:H];
            2'd3: begin
                cell_a = mag1[WIDTH-1:H];
                cell_b = mag2[WIDTH-1:H];
            end
            default: ;
        endcase
    end

    cpu_0_mult_half_cell #(.HW(H)) u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (cell_a),
        .b       (cell_b),
        .p       (cell_p)
    );

    always_comb begin
        pp_ext = {{WIDTH{1'b0}}, cell_p};
        case (pp_k)
            2'd1, 2'd2: pp_ext = {{WIDTH{1'b0}}, cell_p} << H;
            2'd3:       pp_ext = {{WIDTH{1'b0}}, cell_p} << WIDTH;
            default: ;
        endcase
    end

    assign acc_sum = pp_vld ? acc + pp_ext : acc;
    assign prod    = neg_q ? -acc_sum : acc_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            k      <= '0;
            mode_q <= '0;
            neg_q  <= 1'b0;
            mag1   <= '0;
            mag2   <= '0;
            pp_vld <= 1'b0;
            pp_k   <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            pp_vld <= (state == ST_ISSUE);
            pp_k   <= k;
            if (accept) begin
                mode_q <= mode;
                neg_q  <= sign1 ^ sign2;
                // -(-2^(W-1)) wraps to 2^(W-1), which is the correct magnitude.
                mag1   <= sign1 ? -src1 : src1;
                mag2   <= sign2 ? -src2 : src2;
                k      <= '0;
                acc    <= '0;
            end else begin
                acc <= acc_sum;
                if (state == ST_ISSUE) k <= k + 2'd1;
            end
            // Fold in the final partial product directly so result is ready with done.
            if (state == ST_DRAIN)
                result <= (mode_q == MODE_MUL) ? prod[WIDTH-1:0] : prod[AW-1:WIDTH];
        end
    end

endmodule
